condlogic: RTL and testbench
============================

# condlogic

Conditional-execution unit for the multicycle ARM datapath. It sits directly downstream of the instruction decoder and consumes its FlagW, PCS, NextPC, RegW and MemW outputs. It holds the architectural NZCV flags and evaluates the instruction's 4-bit condition field. It gates the decoder's write requests into the final PCWrite, RegWrite and MemWrite strobes that drive the datapath.

## Interface
Parameters: none.

- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high; one clock domain (clk)
- Cond  input  4  Instr[31:28], condition field of the current instruction
- ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle
- FlagW  input  2  flag-write request from the decoder; [1] = N,Z, [0] = C,V
- PCS  input  1  PC written by instruction result (Rd==R15 write or branch)
- NextPC  input  1  unconditional PC+4 update (fetch state)
- RegW  input  1  register-file write request
- MemW  input  1  memory write request
- PCWrite  output  1  PC register enable
- RegWrite  output  1  register-file write enable
- MemWrite  output  1  data-memory write enable
- Flags  output  4  current architectural {N,Z,C,V}, for debug and bench observation

## Operation
- Flag storage: two 2-bit registers with asynchronous clear.
  - NZ loads ALUFlags[3:2] when FlagW[1] & CondEx.
  - CV loads ALUFlags[1:0] when FlagW[0] & CondEx.
- CondEx is combinational from Cond and the stored (pre-update) Flags:
  - 0000 EQ: Z; 0001 NE: ~Z; 0010 CS: C; 0011 CC: ~C
  - 0100 MI: N; 0101 PL: ~N; 0110 VS: V; 0111 VC: ~V
  - 1000 HI: C&~Z; 1001 LS: ~C|Z
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V); 1101 LE: Z|(N!=V)
  - 1110 AL: 1; 1111: 1, treated as AL with no X propagation
- CondExDelayed: 1-bit register loading CondEx on every rising edge (no enable), with asynchronous clear. This carries the execute-state decision into the write-back and memory states.
- PCWrite = (PCS & CondExDelayed) | NextPC.
- RegWrite = RegW & CondExDelayed.
- MemWrite = MemW & CondExDelayed.
- Flags output = {NZ, CV} register contents.

## Timing
- Reset values: Flags = 4'b0000 and CondExDelayed = 0. Consequently, while reset is high, RegWrite = 0, MemWrite = 0 and PCWrite = NextPC.
- Reset asserted mid-instruction clears the flags and CondExDelayed immediately, with no clock required. Any pending write-back is suppressed.
- Flag update latency is 1 cycle. New flags are visible on Flags and used by CondEx in the cycle after the enabling edge.
- When FlagW is active in the same cycle that CondEx is evaluated, CondEx uses the old flags. The write is then gated by that result, so a failed-condition S-instruction leaves flags unchanged.
- A partial write (FlagW = 2'b10) updates only NZ; CV is held.
- The output gating is purely combinational from the inputs and CondExDelayed, adding zero cycles of latency to the decoder strobes.
- NextPC bypasses condition gating entirely, so fetch always advances.

## Structure
- Shared package `arm_pkg`:
  - condition-code localparams (COND_EQ … COND_AL)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
- Sub-module `condcheck` (Cond, Flags -> CondEx): pure combinational, instantiated once.
- Registers use the codebase's existing enable flop with asynchronous reset (`flopenr`) at width 2, and the plain reset flop (`flopr`) at width 1.

## Test plan
- Reset:
  - Pulse reset with NextPC=1, RegW=1 -> Flags=0000, RegWrite=0, PCWrite=1.
  - Deassert reset -> CondExDelayed=0 until the first edge.
- Flag write:
  - Cond=1110, ALUFlags=0100, FlagW=11, one edge -> Flags=0100 next cycle.
  - Then Cond=0000 (EQ) -> CondEx=1.
  - One edge later, RegW=1 -> RegWrite=1.
- Failed condition:
  - Flags=0100, Cond=0001 (NE), FlagW=11, ALUFlags=1001 -> Flags stay 0100.
  - Next cycle RegW=1, MemW=1, PCS=1, NextPC=0 -> RegWrite=MemWrite=PCWrite=0.
- Partial write:
  - Flags=0000, Cond=1110, FlagW=10, ALUFlags=1111 -> Flags=1100 (C,V unchanged).
- Signed conditions:
  - Flags=1001 (N=V=1, Z=0) -> GE, GT, AL give CondEx=1; LT, LE give 0.
  - Flags=1000 -> LT=1, GE=0.
  - Cond=1111 -> CondEx=1.
- Mid-instruction reset:
  - CondExDelayed=1 and RegW=1 (RegWrite=1); assert reset between edges -> RegWrite drops to 0 combinationally and Flags=0000.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: condition codes and flag bit positions shared by the ARM datapath
package arm_pkg;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/condlogic_condcheck.sv
// condcheck: evaluates an ARM condition field against NZCV flags
module condcheck
  import arm_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);
  logic n, z, c, v, ge;
  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);
  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      default: CondEx = 1'b1;
    endcase
  end
endmodule

// File: rtl/flopenr.sv
// flopenr: enabled flop with asynchronous active-high reset
module flopenr #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/flopr.sv
// flopr: plain flop with asynchronous active-high reset
module flopr #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else q <= d;
endmodule

// File: rtl/condlogic.sv
// condlogic: NZCV flag storage and condition gating of decoder write strobes
module condlogic
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);
  logic condex, condexd;
  logic [1:0] nz, cv;
  condcheck u_cc (.Cond(Cond), .Flags(Flags), .CondEx(condex));
  // flag writes are gated by the condition evaluated on the old flags
  flopenr #(2) u_nz (.clk(clk), .reset(reset), .en(FlagW[1] & condex), .d(ALUFlags[3:2]), .q(nz));
  flopenr #(2) u_cv (.clk(clk), .reset(reset), .en(FlagW[0] & condex), .d(ALUFlags[1:0]), .q(cv));
  flopr #(1) u_cxd (.clk(clk), .reset(reset), .d(condex), .q(condexd));
  assign Flags    = {nz, cv};
  assign PCWrite  = (PCS & condexd) | NextPC;
  assign RegWrite = RegW & condexd;
  assign MemWrite = MemW & condexd;
endmodule

// File: tb/tb_condlogic.sv
// tb_condlogic: directed self-checking bench for condlogic
module tb_condlogic;
  logic clk = 0, reset = 0;
  logic [3:0] Cond = 4'b1110, ALUFlags = 0;
  logic [1:0] FlagW = 0;
  logic PCS = 0, NextPC = 0, RegW = 0, MemW = 0;
  logic PCWrite, RegWrite, MemWrite;
  logic [3:0] Flags;
  int checks = 0, errors = 0;

  condlogic dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; NextPC = 1; RegW = 1; Cond = 4'b1110; FlagW = 0;
    #1;
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", Flags); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", RegWrite); end
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL reset_pcwrite got %b exp 1", PCWrite); end
    edge_step();
    reset = 0; NextPC = 0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL post_reset_regwrite got %b exp 0", RegWrite); end
    edge_step();
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL first_edge_regwrite got %b exp 1", RegWrite); end
    RegW = 0;
  endtask

  task automatic test_flag_write();
    Cond = 4'b1110; ALUFlags = 4'b0100; FlagW = 2'b11;
    edge_step();
    FlagW = 0; ALUFlags = 0;
    #1;
    checks++; if (Flags !== 4'b0100) begin errors++; $display("FAIL flagw_flags got %b exp 0100", Flags); end
    Cond = 4'b0000;
    #1;
    checks++; if (dut.condex !== 1'b1) begin errors++; $display("FAIL flagw_eq got %b exp 1", dut.condex); end
    edge_step();
    RegW = 1;
    #1;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL flagw_regwrite got %b exp 1", RegWrite); end
    RegW = 0;
  endtask

  task automatic test_failed_cond();
    Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b1001;
    #1;
    checks++; if (dut.condex !== 1'b0) begin errors++; $display("FAIL ne_condex got %b exp 0", dut.condex); end
    edge_step();
    FlagW = 0;
    RegW = 1; MemW = 1; PCS = 1; NextPC = 0;
    #1;
    checks++; if (Flags !== 4'b0100) begin errors++; $display("FAIL failed_flags got %b exp 0100", Flags); end
    checks++; if ({RegWrite, MemWrite, PCWrite} !== 3'b000) begin errors++; $display("FAIL failed_strobes got %b exp 000", {RegWrite, MemWrite, PCWrite}); end
    NextPC = 1;
    #1;
    checks++; if (PCWrite !== 1'b1) begin errors++; $display("FAIL nextpc_bypass got %b exp 1", PCWrite); end
    RegW = 0; MemW = 0; PCS = 0; NextPC = 0;
  endtask

  task automatic test_partial_write();
    reset = 1; #1; reset = 0;
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1111;
    edge_step();
    FlagW = 0;
    #1;
    checks++; if (Flags !== 4'b1100) begin errors++; $display("FAIL partial_flags got %b exp 1100", Flags); end
  endtask

  task automatic test_signed();
    logic [3:0] conds [6] = '{4'b1010, 4'b1100, 4'b1110, 4'b1011, 4'b1101, 4'b1111};
    logic exp_a [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1001;
    edge_step();
    FlagW = 0;
    checks++; if (Flags !== 4'b1001) begin errors++; $display("FAIL signed_flags got %b exp 1001", Flags); end
    for (int i = 0; i < 6; i++) begin
      Cond = conds[i];
      #1;
      checks++; if (dut.condex !== exp_a[i]) begin errors++; $display("FAIL signed_cond_%b got %b exp %b", conds[i], dut.condex, exp_a[i]); end
    end
    @(negedge clk);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1000;
    edge_step();
    FlagW = 0;
    Cond = 4'b1011; #1;
    checks++; if (dut.condex !== 1'b1) begin errors++; $display("FAIL lt_n_only got %b exp 1", dut.condex); end
    Cond = 4'b1010; #1;
    checks++; if (dut.condex !== 1'b0) begin errors++; $display("FAIL ge_n_only got %b exp 0", dut.condex); end
    Cond = 4'b1111; #1;
    checks++; if (dut.condex !== 1'b1) begin errors++; $display("FAIL cond_1111 got %b exp 1", dut.condex); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    Cond = 4'b1110; FlagW = 0;
    edge_step();
    RegW = 1;
    #1;
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL midreset_pre got %b exp 1", RegWrite); end
    reset = 1;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL midreset_regwrite got %b exp 0", RegWrite); end
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL midreset_flags got %b exp 0000", Flags); end
    edge_step();
    reset = 0; RegW = 0;
  endtask

  initial begin
    test_reset();
    test_flag_write();
    test_failed_cond();
    test_partial_write();
    test_signed();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
